ssio_sdr_in_deskew: RTL and testbench

Multi-lane source-synchronous SDR input with per-lane cycle-level deskew and marker-based automatic alignment. Each lane is captured in an input register. It then passes through a selectable delay line, so all lanes present the same transmit word on the same output cycle. The block sits between the pads of a multi-lane SDR PHY-side interface and the lane-merging MAC/PCS logic, and supersedes single-lane capture where lanes arrive with board or serializer skew.

---
 rtl/ssio_sdr_in_deskew.sv | 192 +++++++++++++++++++
 tb/tb_ssio_sdr_in_deskew.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssio_sdr_in_deskew.sv
// Multi-lane SDR input capture with per-lane cycle deskew. A marker-driven
// search/verify/lock FSM picks each lane's delay so all lanes line up.
module ssio_sdr_in_deskew #(
  parameter int               WIDTH      = 8,
  parameter int               LANES      = 4,
  parameter int               MAX_SKEW   = 3,
  parameter logic [WIDTH-1:0] MARKER     = 8'hBC,
  parameter int               LOCK_COUNT = 2,
  parameter int               TIMEOUT    = 255,
  localparam int              DW         = (MAX_SKEW > 0) ? $clog2(MAX_SKEW + 1) : 1
) (
  input  logic                   input_clk,
  input  logic                   rst_n,
  input  logic [LANES*WIDTH-1:0] input_d,
  input  logic                   train,
  output logic                   output_clk,
  output logic [LANES*WIDTH-1:0] output_q,
  output logic                   output_valid,
  output logic                   locked,
  output logic                   train_error,
  output logic [LANES*DW-1:0]    lane_delay
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int MW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_VERIFY,
    S_LOCKED,
    S_ERROR
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tap_q [LANES][MAX_SKEW+1];
  logic [WIDTH-1:0] out_q [LANES];
  logic [WIDTH-1:0] aligned [LANES];
  logic [DW-1:0]    delay_q [LANES], delay_d [LANES];
  logic [DW-1:0]    arr_q [LANES], arr_d [LANES];
  logic [LANES-1:0] arr_vld_q, arr_vld_d;
  logic             win_open_q, win_open_d;
  logic [DW-1:0]    win_cnt_q, win_cnt_d;
  logic [MW-1:0]    match_cnt_q, match_cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [DW-1:0]    cur_cnt, max_arr;
  logic [LANES-1:0] cap_hit, al_hit;

  // tap_q[l][0] is the pad capture register; deeper taps are the delay line.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      aligned[l] = tap_q[l][delay_q[l]];
      cap_hit[l] = (tap_q[l][0] == MARKER);
      al_hit[l]  = (aligned[l] == MARKER);
    end
  end

  // NOTE: the delay line is a bank of flops rather than a RAM, so every tap
  // is reset; outputs are defined as zero until fresh data has flushed through.
  always_ff @(posedge input_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < LANES; l++) begin
        for (int j = 0; j <= MAX_SKEW; j++) tap_q[l][j] <= '0;
        out_q[l] <= '0;
      end
    end else begin
      for (int l = 0; l < LANES; l++) begin
        tap_q[l][0] <= input_d[l*WIDTH +: WIDTH];
        for (int j = 1; j <= MAX_SKEW; j++) tap_q[l][j] <= tap_q[l][j-1];
        out_q[l] <= aligned[l];
      end
    end
  end

  // NOTE: next-state logic assigns every _d signal a hold value first so that
  // no path through the case statement leaves a signal unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    delay_d     = delay_q;
    arr_d       = arr_q;
    arr_vld_d   = arr_vld_q;
    win_open_d  = win_open_q;
    win_cnt_d   = win_cnt_q;
    match_cnt_d = match_cnt_q;
    tmo_d       = tmo_q;
    cur_cnt     = win_open_q ? win_cnt_q : '0;
    max_arr     = '0;

    if (train) begin
      state_d     = S_SEARCH;
      for (int l = 0; l < LANES; l++) delay_d[l] = '0;
      arr_vld_d   = '0;
      win_open_d  = 1'b0;
      win_cnt_d   = '0;
      match_cnt_d = '0;
      tmo_d       = '0;
    end else begin
      unique case (state_q)
        S_SEARCH: begin
          tmo_d = tmo_q + TW'(1);
          if (win_open_q || (|cap_hit)) begin
            for (int l = 0; l < LANES; l++) begin
              if (cap_hit[l] && !arr_vld_q[l]) begin
                arr_d[l]     = cur_cnt;
                arr_vld_d[l] = 1'b1;
              end
            end
            if (&arr_vld_d) begin
              for (int l = 0; l < LANES; l++)
                if (arr_d[l] > max_arr) max_arr = arr_d[l];
              for (int l = 0; l < LANES; l++) delay_d[l] = max_arr - arr_d[l];
              arr_vld_d   = '0;
              win_open_d  = 1'b0;
              win_cnt_d   = '0;
              match_cnt_d = '0;
              state_d     = S_VERIFY;
            end else if (cur_cnt == DW'(MAX_SKEW)) begin
              arr_vld_d  = '0;
              win_open_d = 1'b0;
              win_cnt_d  = '0;
            end else begin
              win_open_d = 1'b1;
              win_cnt_d  = cur_cnt + DW'(1);
            end
          end
          if (tmo_d == TW'(TIMEOUT)) state_d = S_ERROR;
        end
        S_VERIFY: begin
          tmo_d = tmo_q + TW'(1);
          if (&al_hit) begin
            match_cnt_d = match_cnt_q + MW'(1);
            if (match_cnt_d == MW'(LOCK_COUNT)) state_d = S_LOCKED;
          end else if (|al_hit) begin
            for (int l = 0; l < LANES; l++) delay_d[l] = '0;
            match_cnt_d = '0;
            state_d     = S_SEARCH;
          end
          // A timeout wins over a lock or realign decided in the same cycle.
          if (tmo_d == TW'(TIMEOUT)) state_d = S_ERROR;
        end
        S_LOCKED: begin
          if ((|al_hit) && !(&al_hit)) begin
            for (int l = 0; l < LANES; l++) delay_d[l] = '0;
            match_cnt_d = '0;
            tmo_d       = '0;
            state_d     = S_SEARCH;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: all state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge input_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      arr_vld_q   <= '0;
      win_open_q  <= 1'b0;
      win_cnt_q   <= '0;
      match_cnt_q <= '0;
      tmo_q       <= '0;
      for (int l = 0; l < LANES; l++) begin
        delay_q[l] <= '0;
        arr_q[l]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      arr_vld_q   <= arr_vld_d;
      win_open_q  <= win_open_d;
      win_cnt_q   <= win_cnt_d;
      match_cnt_q <= match_cnt_d;
      tmo_q       <= tmo_d;
      delay_q     <= delay_d;
      arr_q       <= arr_d;
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      output_q[l*WIDTH +: WIDTH] = out_q[l];
      lane_delay[l*DW +: DW]     = delay_q[l];
    end
  end

  assign output_clk   = input_clk;
  assign locked       = (state_q == S_LOCKED);
  assign output_valid = (state_q == S_LOCKED);
  assign train_error  = (state_q == S_ERROR);

endmodule

// File: tb/tb_ssio_sdr_in_deskew.sv
// Randomized bench for ssio_sdr_in_deskew: a cycle model built from lane
// histories and absolute arrival times predicts every output each cycle.
module tb_ssio_sdr_in_deskew;

  localparam int               WIDTH      = 8;
  localparam int               LANES      = 4;
  localparam int               MAX_SKEW   = 3;
  localparam int               LOCK_COUNT = 2;
  localparam int               TIMEOUT    = 255;
  localparam int               DW         = 2;
  localparam int               PERIOD     = 16;
  localparam logic [WIDTH-1:0] MARKER     = 8'hBC;
  localparam int               VW         = LANES*WIDTH + 3 + LANES*DW;

  logic                   input_clk = 1'b0;
  logic                   rst_n;
  logic                   train;
  logic [LANES*WIDTH-1:0] input_d;
  logic                   output_clk;
  logic [LANES*WIDTH-1:0] output_q;
  logic                   output_valid;
  logic                   locked;
  logic                   train_error;
  logic [LANES*DW-1:0]    lane_delay;
  logic [VW-1:0]          dut_vec;

  int n_checks = 0;
  int n_errors = 0;
  int offs [LANES];

  ssio_sdr_in_deskew #(
    .WIDTH(WIDTH), .LANES(LANES), .MAX_SKEW(MAX_SKEW), .MARKER(MARKER),
    .LOCK_COUNT(LOCK_COUNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .input_clk   (input_clk),
    .rst_n       (rst_n),
    .input_d     (input_d),
    .train       (train),
    .output_clk  (output_clk),
    .output_q    (output_q),
    .output_valid(output_valid),
    .locked      (locked),
    .train_error (train_error),
    .lane_delay  (lane_delay)
  );

  always #5 input_clk = ~input_clk;

  assign dut_vec = {output_q, output_valid, locked, train_error, lane_delay};

  // Reference model: hist[l][k] is the word captured k edges ago; arrivals are
  // kept as absolute cycle numbers and converted to offsets when a window closes.
  typedef enum int {M_IDLE, M_SEARCH, M_VERIFY, M_LOCKED, M_ERROR} mstate_e;
  mstate_e          m_state;
  logic [WIDTH-1:0] m_hist [LANES][MAX_SKEW+1];
  logic [WIDTH-1:0] m_out [LANES];
  int               m_dly [LANES];
  int               m_first [LANES];
  int               m_wstart, m_tmo, m_mcnt, m_cyc;

  task automatic model_clear_window();
    for (int l = 0; l < LANES; l++) m_first[l] = -1;
    m_wstart = -1;
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_tmo = 0; m_mcnt = 0; m_cyc = 0;
    model_clear_window();
    for (int l = 0; l < LANES; l++) begin
      m_dly[l] = 0; m_out[l] = '0;
      for (int j = 0; j <= MAX_SKEW; j++) m_hist[l][j] = '0;
    end
  endtask

  task automatic model_step(input bit tr, input logic [LANES*WIDTH-1:0] din);
    logic [WIDTH-1:0] a [LANES];
    bit any_a, all_a, all_seen;
    int mx;
    any_a = 0; all_a = 1;
    m_cyc++;
    for (int l = 0; l < LANES; l++) begin
      a[l] = m_hist[l][m_dly[l]];
      if (a[l] == MARKER) any_a = 1; else all_a = 0;
    end
    if (tr) begin
      m_state = M_SEARCH; m_tmo = 0; m_mcnt = 0;
      for (int l = 0; l < LANES; l++) m_dly[l] = 0;
      model_clear_window();
    end else begin
      case (m_state)
        M_SEARCH: begin
          m_tmo++;
          for (int l = 0; l < LANES; l++)
            if (m_hist[l][0] == MARKER && m_first[l] < 0) begin
              if (m_wstart < 0) m_wstart = m_cyc;
              m_first[l] = m_cyc;
            end
          if (m_wstart >= 0) begin
            all_seen = 1; mx = 0;
            for (int l = 0; l < LANES; l++)
              if (m_first[l] < 0) all_seen = 0;
              else if (m_first[l] - m_wstart > mx) mx = m_first[l] - m_wstart;
            if (all_seen) begin
              for (int l = 0; l < LANES; l++) m_dly[l] = mx - (m_first[l] - m_wstart);
              m_mcnt = 0; model_clear_window(); m_state = M_VERIFY;
            end else if (m_cyc - m_wstart >= MAX_SKEW) model_clear_window();
          end
          if (m_tmo >= TIMEOUT) m_state = M_ERROR;
        end
        M_VERIFY: begin
          m_tmo++;
          if (any_a && all_a) begin
            m_mcnt++;
            if (m_mcnt >= LOCK_COUNT) m_state = M_LOCKED;
          end else if (any_a) begin
            for (int l = 0; l < LANES; l++) m_dly[l] = 0;
            m_mcnt = 0; m_state = M_SEARCH;
          end
          if (m_tmo >= TIMEOUT) m_state = M_ERROR;
        end
        M_LOCKED: begin
          if (any_a && !all_a) begin
            for (int l = 0; l < LANES; l++) m_dly[l] = 0;
            m_mcnt = 0; m_tmo = 0; m_state = M_SEARCH;
          end
        end
        default: ;
      endcase
    end
    for (int l = 0; l < LANES; l++) begin
      m_out[l] = a[l];
      for (int j = MAX_SKEW; j >= 1; j--) m_hist[l][j] = m_hist[l][j-1];
      m_hist[l][0] = din[l*WIDTH +: WIDTH];
    end
  endtask

  function automatic logic [VW-1:0] model_vec();
    logic [LANES*WIDTH-1:0] q;
    logic [LANES*DW-1:0]    d;
    for (int l = 0; l < LANES; l++) begin
      q[l*WIDTH +: WIDTH] = m_out[l];
      d[l*DW +: DW]       = DW'(m_dly[l]);
    end
    return {q, m_state == M_LOCKED, m_state == M_LOCKED, m_state == M_ERROR, d};
  endfunction

  function automatic logic [LANES-1:0] sched(input int i);
    logic [LANES-1:0] m;
    for (int l = 0; l < LANES; l++) m[l] = (i >= offs[l]) && ((i - offs[l]) % PERIOD == 0);
    return m;
  endfunction

  // Drives one cycle (marker on lanes in mk, random non-marker data elsewhere)
  // and advances the model on the same edge; returns 1 time unit after it.
  task automatic step(input bit tr, input logic [LANES-1:0] mk);
    logic [WIDTH-1:0] w;
    for (int l = 0; l < LANES; l++) begin
      w = WIDTH'($urandom);
      if (w == MARKER) w = ~w;
      if (mk[l]) w = MARKER;
      input_d[l*WIDTH +: WIDTH] = w;
    end
    train = tr;
    @(posedge input_clk);
    model_step(tr, input_d);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; train = 1'b0; input_d = '0;
    model_reset();
    #12;
    n_checks++;
    if (dut_vec !== '0) begin
      n_errors++; $display("FAIL reset_values: got %h expected 0", dut_vec);
    end
    rst_n = 1'b1;
    step(0, '0);
    step(1, '0);
    offs = '{0, 0, 0, 0};
    for (int i = 0; i < 20; i++) begin
      step(0, sched(i));
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_errors++; $display("FAIL reset_pre model: cycle %0d got %h expected %h", i, dut_vec, model_vec());
      end
    end
    n_checks++;
    if (locked !== 1'b0) begin
      n_errors++; $display("FAIL verify_not_locked: got %b expected 0", locked);
    end
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec !== '0) begin
      n_errors++; $display("FAIL reset_mid_verify: got %h expected 0", dut_vec);
    end
    n_checks++;
    if (output_clk !== input_clk) begin
      n_errors++; $display("FAIL output_clk: got %b expected %b", output_clk, input_clk);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4*PERIOD; i++) begin
      step(0, sched(i));
      n_checks++;
      if (dut_vec !== model_vec() || locked !== 1'b0) begin
        n_errors++; $display("FAIL no_train_lock: cycle %0d got %h expected %h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_zero_skew();
    logic [LANES*WIDTH-1:0] prev;
    offs = '{0, 0, 0, 0};
    step(1, '0);
    prev = input_d;
    for (int i = 0; i < 4*PERIOD; i++) begin
      step(0, sched(i));
      n_checks++;
      if (dut_vec !== model_vec() || output_q !== prev) begin
        n_errors++; $display("FAIL zero_skew: cycle %0d got %h expected %h (q want %h)", i, dut_vec, model_vec(), prev);
      end
      prev = input_d;
    end
    n_checks++;
    if (locked !== 1'b1 || lane_delay !== '0) begin
      n_errors++; $display("FAIL zero_skew_lock: got locked=%b delay=%h expected 1/00", locked, lane_delay);
    end
  endtask

  task automatic test_skew();
    int nm;
    bit saw_all;
    saw_all = 0;
    offs = '{0, 1, 3, 2};
    step(1, '0);
    for (int i = 0; i < 4*PERIOD; i++) begin
      step(0, sched(i));
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_errors++; $display("FAIL skew_model: cycle %0d got %h expected %h", i, dut_vec, model_vec());
      end
      if (locked === 1'b1) begin
        nm = 0;
        for (int l = 0; l < LANES; l++) if (output_q[l*WIDTH +: WIDTH] == MARKER) nm++;
        if (nm == LANES) saw_all = 1;
        n_checks++;
        if (nm != 0 && nm != LANES) begin
          n_errors++; $display("FAIL skew_marker_together: cycle %0d got %0d lanes expected %0d", i, nm, LANES);
        end
      end
    end
    n_checks++;
    if (locked !== 1'b1 || lane_delay !== 8'h4B || !saw_all) begin
      n_errors++; $display("FAIL skew_lock: got locked=%b delay=%h all=%b expected 1/4b/1", locked, lane_delay, saw_all);
    end
  endtask

  task automatic test_relock();
    bit saw_drop;
    saw_drop = 0;
    offs = '{0, 0, 3, 2};
    for (int i = 0; i < 4*PERIOD; i++) begin
      step(0, sched(i));
      if (locked === 1'b0) saw_drop = 1;
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_errors++; $display("FAIL relock_model: cycle %0d got %h expected %h", i, dut_vec, model_vec());
      end
    end
    n_checks++;
    if (!saw_drop || locked !== 1'b1 || lane_delay !== 8'h4F) begin
      n_errors++; $display("FAIL relock: got drop=%b locked=%b delay=%h expected 1/1/4f", saw_drop, locked, lane_delay);
    end
  endtask

  task automatic test_random_skew();
    logic [LANES*DW-1:0] exp_d;
    int mx;
    for (int r = 0; r < 3; r++) begin
      mx = 0;
      for (int l = 0; l < LANES; l++) begin
        offs[l] = $urandom_range(0, MAX_SKEW);
        if (offs[l] > mx) mx = offs[l];
      end
      for (int l = 0; l < LANES; l++) exp_d[l*DW +: DW] = DW'(mx - offs[l]);
      step(1, '0);
      for (int i = 0; i < 4*PERIOD; i++) begin
        step(0, sched(i));
        n_checks++;
        if (dut_vec !== model_vec()) begin
          n_errors++; $display("FAIL random_skew_model: run %0d cycle %0d got %h expected %h", r, i, dut_vec, model_vec());
        end
      end
      n_checks++;
      if (locked !== 1'b1 || lane_delay !== exp_d) begin
        n_errors++; $display("FAIL random_skew_lock: run %0d got locked=%b delay=%h expected 1/%h", r, locked, lane_delay, exp_d);
      end
    end
  endtask

  task automatic test_excess_skew();
    bit saw_lock;
    int first_err;
    saw_lock = 0; first_err = -1;
    offs = '{0, 1, 3, 4};
    step(1, '0);
    for (int i = 0; i < 17*PERIOD; i++) begin
      step(0, sched(i));
      if (locked === 1'b1) saw_lock = 1;
      if (train_error === 1'b1 && first_err < 0) first_err = i;
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_errors++; $display("FAIL excess_model: cycle %0d got %h expected %h", i, dut_vec, model_vec());
      end
    end
    n_checks++;
    if (saw_lock || first_err != TIMEOUT - 1) begin
      n_errors++; $display("FAIL excess_timeout: got lock=%b err_cycle=%0d expected 0/%0d", saw_lock, first_err, TIMEOUT - 1);
    end
  endtask

  task automatic test_restart();
    step(1, '0);
    step(0, 4'b0001);
    step(0, '0);
    step(1, '0);
    offs = '{1, 0, 0, 0};
    for (int i = 0; i < 4*PERIOD; i++) begin
      step(0, sched(i));
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_errors++; $display("FAIL restart_model: cycle %0d got %h expected %h", i, dut_vec, model_vec());
      end
      if (i == 2) begin
        n_checks++;
        if (lane_delay !== 8'h54) begin
          n_errors++; $display("FAIL restart_window: got delay=%h expected 54", lane_delay);
        end
      end
    end
    n_checks++;
    if (locked !== 1'b1 || lane_delay !== 8'h54) begin
      n_errors++; $display("FAIL restart_lock: got locked=%b delay=%h expected 1/54", locked, lane_delay);
    end
  endtask

  initial begin
    test_reset();
    test_zero_skew();
    test_skew();
    test_relock();
    test_random_skew();
    test_excess_skew();
    test_restart();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
